// File: rtl/mem_pkg.sv
// Shared definitions for the I/D memory arbiter: FSM state encoding and
// default address/line widths.
package mem_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-requester arbitration decision: fixed D priority, or round-robin
// against a "D served last" pointer when RR_EN is set.
module arb_pick #(
  parameter bit RR_EN = 1'b0
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_d
);

  always_comb begin
    grant_d = req_d;
    if (req_i && req_d) begin
      grant_d = RR_EN ? ~last_d : 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/write-backs onto one memory port.
// Define ARB_RR_EN for round-robin on conflicts; otherwise D always wins.
//
// Handshake: each requester holds its level request until its ready pulses
// (one cycle in RELEASE); memory holds nothing, the arbiter keeps mem_*
// stable from grant until the single cycle where mem_ready is seen.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_e            state_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic              d_req;
  logic              last_d;
  logic              grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
  logic last_d_q;
  assign last_d = last_d_q;
`else
  assign last_d = 1'b0;
`endif

  arb_pick #(.RR_EN(RR_EN)) u_arb_pick (
    .req_i   (i_read),
    .req_d   (d_req),
    .last_d  (last_d),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_read || d_req) begin
            // A D request with both read and write set is a write-back.
            state_q     <= grant_d ? SERVE_D : SERVE_I;
            mem_addr_q  <= grant_d ? d_addr : i_addr;
            mem_wdata_q <= grant_d ? d_wdata : '0;
            mem_write_q <= grant_d & d_write;
            mem_read_q  <= grant_d ? ~d_write : 1'b1;
`ifdef ARB_RR_EN
            last_d_q    <= grant_d;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ready) begin
            if (mem_read_q) begin
              if (state_q == SERVE_I) i_rdata_q <= mem_rdata;
              else                    d_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= (state_q == SERVE_I);
            d_ready_q   <= (state_q == SERVE_D);
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench-side memory responder, a per-cycle
// reference model of ready/rdata, and hand-computed literal checks.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a completion accepted by the responder becomes a
  // one-cycle ready for its owner and, for reads, the owner's new rdata
  logic          pend_valid = 1'b0;
  logic          pend_d = 1'b0;
  logic          pend_read = 1'b0;
  logic [LW-1:0] pend_data = '0;
  logic          exp_i_ready, exp_d_ready;
  logic [LW-1:0] exp_i_rdata, exp_d_rdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_i_ready <= 1'b0;
      exp_d_ready <= 1'b0;
      exp_i_rdata <= '0;
      exp_d_rdata <= '0;
    end else begin
      exp_i_ready <= pend_valid && !pend_d;
      exp_d_ready <= pend_valid && pend_d;
      if (pend_valid && pend_read) begin
        if (pend_d) exp_d_rdata <= pend_data;
        else        exp_i_rdata <= pend_data;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_rw_excl", {127'b0, mem_read & mem_write}, '0);
      chk("cyc_i_ready", {127'b0, i_ready}, {127'b0, exp_i_ready});
      chk("cyc_d_ready", {127'b0, d_ready}, {127'b0, exp_d_ready});
      chk("cyc_i_rdata", i_rdata, exp_i_rdata);
      chk("cyc_d_rdata", d_rdata, exp_d_rdata);
    end
  end

  // requesters drop their level request once they see their ready
  initial forever begin
    @(negedge clk);
    if (i_ready) i_read = 1'b0;
    if (d_ready) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // memory responder: waits for the command, checks it stays put, completes it
  task automatic serve(input bit exp_wr, input logic [AW-1:0] exp_addr,
                       input logic [LW-1:0] exp_wdata, input bit owner_d,
                       input int exp_wait, input int delay,
                       input logic [LW-1:0] rdata, input bit perturb,
                       input string tag);
    int  w = 0;
    bit  seen = 1'b0;
    while (!seen && w < 20) begin
      @(negedge clk);
      w++;
      seen = mem_read | mem_write;
    end
    chk({tag, "_seen"}, {127'b0, seen}, 128'd1);
    if (!seen) return;
    chk({tag, "_latency"}, LW'(w), LW'(exp_wait));
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_mem_write"}, {127'b0, mem_write}, {127'b0, exp_wr});
      chk({tag, "_mem_read"}, {127'b0, mem_read}, {127'b0, !exp_wr});
      chk({tag, "_mem_addr"}, LW'(mem_addr), LW'(exp_addr));
      if (exp_wr) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
      if (perturb && i == 0) begin
        i_addr  = AW'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
    end
    mem_ready  = 1'b1;
    mem_rdata  = rdata;
    pend_valid = 1'b1;
    pend_d     = owner_d;
    pend_read  = !exp_wr;
    pend_data  = rdata;
    @(negedge clk);
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    pend_valid = 1'b0;
    chk({tag, "_owner_ready"}, {127'b0, owner_d ? d_ready : i_ready}, 128'd1);
    chk({tag, "_other_ready"}, {127'b0, owner_d ? i_ready : d_ready}, '0);
    chk({tag, "_cmd_dropped"}, {126'b0, mem_read, mem_write}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // reset values
    #1;
    chk("rst_mem_cmd", {126'b0, mem_read, mem_write}, '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    chk("rst_ready", {126'b0, i_ready, d_ready}, '0);
    chk("rst_state", LW'(dbg_state), LW'(mem_pkg::IDLE));
    idle(2);
    rst = 1'b1;

    // I-only read, memory answers 5 cycles after the command
    idle(2);
    i_addr = 28'h0000010; i_read = 1'b1;
    serve(1'b0, 28'h0000010, '0, 1'b0, 1, 5, {16{8'hA5}}, 1'b0, "t035");
    chk("t035_i_rdata", i_rdata, {16{8'hA5}});
    @(negedge clk);
    chk("t035_pulse_end", {127'b0, i_ready}, '0);

    // stray mem_ready while idle
    idle(2);
    mem_ready = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    chk("t040_ready", {126'b0, i_ready, d_ready}, '0);
    chk("t040_i_rdata", i_rdata, {16{8'hA5}});
    chk("t040_state", LW'(dbg_state), LW'(mem_pkg::IDLE));

    // D refill so write-backs have an rdata value to leave alone
    idle(2);
    d_addr = 28'h0000030; d_read = 1'b1;
    serve(1'b0, 28'h0000030, '0, 1'b1, 1, 2, {8{16'h5A3C}}, 1'b0, "dread");
    chk("dread_d_rdata", d_rdata, {8{16'h5A3C}});

    // D write-back; request inputs scrambled while it is served
    idle(2);
    d_addr = 28'h0000020; d_wdata = 128'h123456789ABCDEF0_0FEDCBA987654321; d_write = 1'b1;
    serve(1'b1, 28'h0000020, 128'h123456789ABCDEF0_0FEDCBA987654321, 1'b1, 1, 3, '1, 1'b1, "t036");
    chk("t036_d_rdata", d_rdata, {8{16'h5A3C}});

    // read and write together is a write
    idle(2);
    d_addr = 28'h0000040; d_wdata = {4{32'hCAFEF00D}}; d_read = 1'b1; d_write = 1'b1;
    serve(1'b1, 28'h0000040, {4{32'hCAFEF00D}}, 1'b1, 1, 1, '1, 1'b0, "t038");
    chk("t038_d_rdata", d_rdata, {8{16'h5A3C}});

    // reset during SERVE_I aborts, request is re-served afterwards
    idle(2);
    i_addr = 28'h0000050; i_read = 1'b1;
    w = 0;
    while (!mem_read && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t039_cmd_seen", {127'b0, mem_read}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t039_mem_read", {127'b0, mem_read}, '0);
    chk("t039_state", LW'(dbg_state), LW'(mem_pkg::IDLE));
    chk("t039_i_rdata", i_rdata, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t039_no_ready", {126'b0, i_ready, d_ready}, '0);
    end
    rst = 1'b1;
    serve(1'b0, 28'h0000050, '0, 1'b0, 1, 1, {4{32'h0BADC0DE}}, 1'b0, "t039_reserve");
    chk("t039_i_rdata_new", i_rdata, {4{32'h0BADC0DE}});

    // fresh reset so the round-robin pointer starts at "I last"
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    // first conflict: D wins in both configurations
    i_addr = 28'h0000060; d_addr = 28'h0000070; i_read = 1'b1; d_read = 1'b1;
    serve(1'b0, 28'h0000070, '0, 1'b1, 1, 2, {4{32'h11112222}}, 1'b0, "c1_d");
    serve(1'b0, 28'h0000060, '0, 1'b0, 2, 1, {4{32'h33334444}}, 1'b0, "c1_i");

    // D-only read leaves D as last served
    idle(2);
    d_addr = 28'h0000080; d_read = 1'b1;
    serve(1'b0, 28'h0000080, '0, 1'b1, 1, 1, {4{32'h55556666}}, 1'b0, "mid_d");

    // second conflict
    idle(2);
    i_addr = 28'h0000090; d_addr = 28'h00000A0; i_read = 1'b1; d_read = 1'b1;
`ifdef ARB_RR_EN
    serve(1'b0, 28'h0000090, '0, 1'b0, 1, 2, {4{32'h77778888}}, 1'b0, "c2_i");
    serve(1'b0, 28'h00000A0, '0, 1'b1, 2, 1, {4{32'h9999AAAA}}, 1'b0, "c2_d");
    chk("c2_i_rdata", i_rdata, {4{32'h77778888}});
`else
    serve(1'b0, 28'h00000A0, '0, 1'b1, 1, 2, {4{32'h9999AAAA}}, 1'b0, "c2_d");
    serve(1'b0, 28'h0000090, '0, 1'b0, 2, 1, {4{32'h77778888}}, 1'b0, "c2_i");
    chk("c2_i_rdata", i_rdata, {4{32'h77778888}});
`endif
    chk("c2_d_rdata", d_rdata, {4{32'h9999AAAA}});

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, block (128-bit line) address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_read  input  1  I-cache line read request, level, held until i_ready.
REQ-006 SHALL have port i_addr  input  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_rdata  output  LINE_W  I-cache returned line.
REQ-008 SHALL have port i_ready  output  1  I-cache completion pulse.
REQ-009 SHALL have port d_read  input  1  D-cache line read (refill) request, level.
REQ-010 SHALL have port d_write  input  1  D-cache line write-back request, level.
REQ-011 SHALL have port d_addr  input  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_wdata  input  LINE_W  D-cache write-back line.
REQ-013 SHALL have port d_rdata  output  LINE_W  D-cache returned line.
REQ-014 SHALL have port d_ready  output  1  D-cache completion pulse.
REQ-015 SHALL have ports mem_read/mem_write  output  1 each  shared memory commands.
REQ-016 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  LINE_W  shared memory address/data.
REQ-017 SHALL have ports mem_rdata  input  LINE_W, mem_ready  input  1  memory data and completion.

Function
REQ-018 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RELEASE.
REQ-019 IDLE: no request -> stay; request(s) present -> arbitrate, enter SERVE_I or SERVE_D next cycle.
REQ-020 SERVE_x: mem_read/mem_write/mem_addr/mem_wdata SHALL be registered from owner's request latched at grant, stable until mem_ready.
REQ-021 Grant-to-command latency SHALL be exactly 1 cycle (request seen in IDLE at edge N -> mem_* valid after edge N).
REQ-022 SERVE_x with mem_ready=1: capture mem_rdata into owner's rdata register (reads only), deassert mem_*, enter RELEASE.
REQ-023 RELEASE: owner's ready SHALL be 1 for exactly one cycle, then IDLE; non-owner ready SHALL stay 0.
REQ-024 d_read and d_write both 1 SHALL be served as a write; d_rdata unchanged by writes.
REQ-025 i_rdata/d_rdata SHALL hold last captured value until next owner read completes.
REQ-026 mem_ready in IDLE or RELEASE SHALL be ignored.
REQ-027 Requests changing during SERVE_x SHALL not alter mem_* (latched copy used).
REQ-028 mem_read and mem_write SHALL never be 1 simultaneously; at most one ready asserted per cycle.

Reset
REQ-029 rst low SHALL force IDLE, all outputs 0 (rdata registers 0), round-robin pointer to "I last".
REQ-030 rst mid-transaction SHALL abort immediately; no ready pulse is issued for the aborted request.

Configuration
REQ-031 With ARB_RR_EN defined, simultaneous I and D requests SHALL be granted round-robin: requester not served last wins; pointer updates on entering SERVE_x.
REQ-032 Without ARB_RR_EN, D-cache SHALL always win simultaneous requests (fixed priority); no pointer register exists.

Structure
REQ-033 State encoding, ADDR_W/LINE_W defaults SHALL reside in shared package mem_pkg.
REQ-034 Arbitration decision SHALL be a sub-module arb_pick (inputs: two requests, pointer; output: grant), single-level instance.

Verification
REQ-035 I-only read addr 0x0000010, mem_ready 5 cycles later with 0xA5..A5 -> mem_read after 1 cycle, i_rdata=0xA5..A5, single i_ready pulse.
REQ-036 D write addr 0x0000020, wdata 0x1234..: mem_write=1, mem_wdata matches, d_ready one pulse, d_rdata unchanged.
REQ-037 I and D read same cycle, ARB_RR_EN off -> D served first, I served after D's RELEASE+IDLE; with ARB_RR_EN after reset -> D first, next conflict -> I first.
REQ-038 d_read=d_write=1 -> mem_write=1, mem_read=0.
REQ-039 rst pulled low during SERVE_I -> mem_read=0, i_ready never pulses, FSM IDLE; request re-served after rst release.
REQ-040 mem_ready asserted while IDLE -> no ready pulse, no rdata change.
